// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and opcodes for the single-cycle MIPS core.
// Run-control state encoding plus the opcodes the control decoder recognises.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;

endpackage

// File: rtl/instr_fetch_unit_imem.sv
// Instruction memory: synchronous write, asynchronous read, no reset.
// Contents survive core reset so a loaded program can be re-run.
module imem_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, loadable instruction memory, next-PC mux
// and the IDLE/RUN/HALT/FAULT run-control FSM.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP    = OP_HALT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        en,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [31:0] prog_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        fetch_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] icount
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  icount_q;
  logic         fetch_valid_q;
  logic         halted_q;
  logic         fault_q;

  logic [31:0]  mem_rdata;
  logic         mem_we;
  logic [31:0]  next_pc_d;
  logic [31:0]  next_widx;
  logic         next_bad;

  // Writes are gated by reset too, so reset wins over an in-flight load.
  assign mem_we = rst_n && prog_we && (state_q == IDLE);

  imem_ram #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (AW'(prog_addr)),
    .wdata (prog_data),
    .raddr (pc_q[AW+1:2]),
    .rdata (mem_rdata)
  );

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = fetch_valid_q ? mem_rdata : '0;
  assign opcode      = instr[31:26];
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign icount      = icount_q;

  always_comb begin
    next_pc_d = pc_plus4;
    if (jump)
      next_pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc_d = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  end

  assign next_widx = {2'b00, next_pc_d[31:2]};
  assign next_bad  = (next_pc_d[1:0] != 2'b00) || (next_widx >= IMEM_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= PC_RESET;
      icount_q      <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (en) begin
            if (icount_q != '1) icount_q <= icount_q + 32'd1;
            // HALT is checked first: the halting instruction never redirects the PC.
            if (opcode == HALT_OP) begin
              state_q       <= HALT;
              fetch_valid_q <= 1'b0;
              halted_q      <= 1'b1;
            end else if (next_bad) begin
              state_q       <= FAULT;
              fetch_valid_q <= 1'b0;
              fault_q       <= 1'b1;
            end else begin
              pc_q <= next_pc_d;
            end
          end
        end
        HALT:    state_q <= HALT;
        FAULT:   state_q <= FAULT;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
